// File: rtl/xgmii_rx_frame_checker.sv
// XGMII-64 receive frame checker for 10GBASE-R loopback testing.
// Parses start/preamble/payload/terminate words, checks an incrementing-byte
// payload pattern and the payload length, then reports per-frame status
// pulses and keeps saturating good-frame and error counters.
module xgmii_rx_frame_checker #(
    parameter int MIN_LEN = 64,
    parameter int MAX_LEN = 1518,
    parameter int CNT_W   = 32
) (
    input  logic             clk_156,
    input  logic             rst_156_n,
    input  logic             rx_rdy,
    input  logic [63:0]      rx_data,
    input  logic [7:0]       rx_ctrl,
    input  logic             rx_ena,
    output logic             frame_ok,
    output logic             frame_err,
    output logic [2:0]       err_code,
    output logic [15:0]      last_len,
    output logic [CNT_W-1:0] frame_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    localparam logic [7:0] CH_START = 8'hFB;
    localparam logic [7:0] CH_TERM  = 8'hFD;
    localparam logic [7:0] CH_IDLE  = 8'h07;
    localparam logic [7:0] CH_PRE   = 8'h55;
    localparam logic [7:0] CH_SFD   = 8'hD5;

    localparam logic [2:0] E_NONE  = 3'd0;
    localparam logic [2:0] E_PRE   = 3'd1;
    localparam logic [2:0] E_ALIGN = 3'd2;
    localparam logic [2:0] E_CTRL  = 3'd3;
    localparam logic [2:0] E_PAT   = 3'd4;
    localparam logic [2:0] E_SHORT = 3'd5;
    localparam logic [2:0] E_LONG  = 3'd6;

    localparam logic [15:0] LEN_CAP = 16'(MAX_LEN + 1);
    localparam logic [15:0] LEN_MIN = 16'(MIN_LEN);
    localparam logic [16:0] LEN_MAX = 17'(MAX_LEN);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_DROP = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [1:0]  rst_sync;
    logic        rst_n;

    logic [15:0] len, len_nxt;
    logic [7:0]  seed, seed_nxt;
    logic        seed_set, seed_set_nxt;
    logic        pat_err, pat_err_nxt;

    logic        ok_nxt, err_nxt;
    logic [2:0]  code_nxt;
    logic [15:0] last_len_nxt;

    logic [7:0]  lane [8];
    logic [3:0]  term_idx;
    logic        term_is_fd;
    logic        preamble_ok;
    logic        start_word;
    logic        lane4_start;
    logic        drop_exit;
    logic        tail_bad;
    logic        word_mism;
    logic [7:0]  pat_base;
    logic [7:0]  exp_byte;
    logic [16:0] len_sum;
    logic [15:0] len_sat;
    logic        len_long;

    // Async assert, synchronised release of the internal reset
    always_ff @(posedge clk_156 or negedge rst_156_n) begin
        if (!rst_156_n) rst_sync <= 2'b00;
        else            rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_n = rst_sync[1];

    // Split the word into lanes and locate the first control lane
    always_comb begin
        term_idx = 4'd8;
        for (int k = 0; k < 8; k++) lane[k] = rx_data[8*k +: 8];
        for (int k = 7; k >= 0; k--) begin
            if (rx_ctrl[k]) term_idx = 4'(k);
        end
    end

    // Start / preamble / drop-exit / terminate-tail classification of the word
    always_comb begin
        preamble_ok = (lane[7] == CH_SFD);
        for (int k = 1; k < 7; k++) begin
            if (lane[k] != CH_PRE) preamble_ok = 1'b0;
        end
        start_word  = (rx_ctrl == 8'h01) && (lane[0] == CH_START);
        lane4_start = rx_ctrl[4] && (lane[4] == CH_START);
        term_is_fd  = (term_idx != 4'd8) && (lane[term_idx[2:0]] == CH_TERM);

        drop_exit = (rx_ctrl == 8'hFF) && (rx_data == {8{CH_IDLE}});
        tail_bad  = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (rx_ctrl[k] && lane[k] == CH_TERM) drop_exit = 1'b1;
            if (4'(k) > term_idx && !(rx_ctrl[k] && lane[k] == CH_IDLE)) tail_bad = 1'b1;
        end
    end

    // Payload pattern check: byte n must equal seed + n; seed is the first payload byte
    always_comb begin
        pat_base  = seed_set ? seed : lane[0];
        word_mism = 1'b0;
        exp_byte  = 8'h00;
        for (int k = 0; k < 8; k++) begin
            exp_byte = pat_base + len[7:0] + 8'(k);
            if (4'(k) < term_idx && lane[k] != exp_byte) word_mism = 1'b1;
        end
    end

    // Running payload length, saturated one above the maximum so it never wraps
    always_comb begin
        len_sum  = {1'b0, len} + {13'd0, term_idx};
        len_sat  = (len_sum > {1'b0, LEN_CAP}) ? LEN_CAP : len_sum[15:0];
        len_long = (len_sum > LEN_MAX);
    end

    // FSM state register
    always_ff @(posedge clk_156 or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Next-state, frame bookkeeping and status decisions
    always_comb begin
        state_nxt    = state;
        len_nxt      = len;
        seed_nxt     = seed;
        seed_set_nxt = seed_set;
        pat_err_nxt  = pat_err;
        ok_nxt       = 1'b0;
        err_nxt      = 1'b0;
        code_nxt     = err_code;
        last_len_nxt = last_len;

        if (!rx_rdy) begin
            state_nxt = ST_IDLE;
        end else if (rx_ena) begin
            case (state)
                ST_IDLE: begin
                    if (start_word && preamble_ok) begin
                        state_nxt    = ST_DATA;
                        len_nxt      = 16'd0;
                        seed_set_nxt = 1'b0;
                        pat_err_nxt  = 1'b0;
                    end else if (start_word) begin
                        err_nxt  = 1'b1;
                        code_nxt = E_PRE;
                    end else if (lane4_start) begin
                        err_nxt   = 1'b1;
                        code_nxt  = E_ALIGN;
                        state_nxt = ST_DROP;
                    end
                end
                ST_DATA: begin
                    len_nxt     = len_sat;
                    pat_err_nxt = pat_err | word_mism;
                    if (!seed_set && term_idx != 4'd0) begin
                        seed_set_nxt = 1'b1;
                        seed_nxt     = lane[0];
                    end
                    if (len_long) begin
                        // Oversize: report once; only a terminated word returns straight to IDLE
                        err_nxt   = 1'b1;
                        code_nxt  = E_LONG;
                        state_nxt = (term_idx == 4'd8) ? ST_DROP : ST_IDLE;
                    end else if (term_is_fd) begin
                        last_len_nxt = len_sat;
                        state_nxt    = ST_IDLE;
                        if (tail_bad) begin
                            err_nxt  = 1'b1;
                            code_nxt = E_CTRL;
                        end else if (pat_err_nxt) begin
                            err_nxt  = 1'b1;
                            code_nxt = E_PAT;
                        end else if (len_sat < LEN_MIN) begin
                            err_nxt  = 1'b1;
                            code_nxt = E_SHORT;
                        end else begin
                            ok_nxt = 1'b1;
                        end
                    end else if (term_idx != 4'd8) begin
                        // Unexpected control char mid-frame; the word is consumed here
                        err_nxt   = 1'b1;
                        code_nxt  = E_CTRL;
                        state_nxt = ST_IDLE;
                    end
                end
                ST_DROP: begin
                    if (drop_exit) state_nxt = ST_IDLE;
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    // Frame context, registered status outputs and saturating counters
    always_ff @(posedge clk_156 or negedge rst_n) begin
        if (!rst_n) begin
            len       <= 16'd0;
            seed      <= 8'h00;
            seed_set  <= 1'b0;
            pat_err   <= 1'b0;
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
            err_code  <= E_NONE;
            last_len  <= 16'd0;
            frame_cnt <= '0;
            err_cnt   <= '0;
        end else begin
            len       <= len_nxt;
            seed      <= seed_nxt;
            seed_set  <= seed_set_nxt;
            pat_err   <= pat_err_nxt;
            frame_ok  <= ok_nxt;
            frame_err <= err_nxt;
            err_code  <= code_nxt;
            last_len  <= last_len_nxt;
            if (ok_nxt && frame_cnt != '1) frame_cnt <= frame_cnt + CNT_W'(1);
            if (err_nxt && err_cnt != '1)  err_cnt   <= err_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_xgmii_rx_frame_checker.sv
// Directed bench for xgmii_rx_frame_checker: good frames, pattern/preamble/
// alignment/control/length errors, rx_rdy drop, rx_ena bubbles and async reset.
`timescale 1ns/1ps
module tb_xgmii_rx_frame_checker;

    localparam logic [63:0] IDLE_W  = 64'h0707070707070707;
    localparam logic [63:0] START_W = 64'hD5555555555555FB;

    logic        clk_156 = 1'b0;
    logic        rst_156_n;
    logic        rx_rdy;
    logic [63:0] rx_data;
    logic [7:0]  rx_ctrl;
    logic        rx_ena;
    logic        frame_ok;
    logic        frame_err;
    logic [2:0]  err_code;
    logic [15:0] last_len;
    logic [31:0] frame_cnt;
    logic [31:0] err_cnt;

    int checks = 0;
    int errors = 0;
    int ok_seen = 0;
    int err_seen = 0;
    int both_seen = 0;
    int ok0;
    int err0;

    xgmii_rx_frame_checker #(.MIN_LEN(64), .MAX_LEN(1518), .CNT_W(32)) dut (
        .clk_156   (clk_156),
        .rst_156_n (rst_156_n),
        .rx_rdy    (rx_rdy),
        .rx_data   (rx_data),
        .rx_ctrl   (rx_ctrl),
        .rx_ena    (rx_ena),
        .frame_ok  (frame_ok),
        .frame_err (frame_err),
        .err_code  (err_code),
        .last_len  (last_len),
        .frame_cnt (frame_cnt),
        .err_cnt   (err_cnt)
    );

    // 156.25 MHz clock
    always #3.2 clk_156 = ~clk_156;

    // Pulse monitor, sampled on the falling edge
    always @(negedge clk_156) begin
        if (frame_ok === 1'b1) ok_seen++;
        if (frame_err === 1'b1) err_seen++;
        if (frame_ok === 1'b1 && frame_err === 1'b1) both_seen++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic send_word(input logic [7:0] c, input logic [63:0] d);
        @(negedge clk_156);
        rx_ena  = 1'b1;
        rx_ctrl = c;
        rx_data = d;
    endtask

    task automatic bubble();
        @(negedge clk_156);
        rx_ena  = 1'b0;
        rx_ctrl = 8'h01;
        rx_data = 64'h07070707070707FD;
    endtask

    task automatic idle(input int n);
        repeat (n) send_word(8'hFF, IDLE_W);
    endtask

    function automatic logic [63:0] pay_word(input logic [7:0] seed, input int idx,
                                             input int bad_idx, input logic [7:0] bad_val);
        logic [63:0] w;
        for (int k = 0; k < 8; k++)
            w[8*k +: 8] = (idx + k == bad_idx) ? bad_val : seed + 8'(idx + k);
        return w;
    endfunction

    task automatic send_frame(input logic [7:0] seed, input int len, input int bad_idx,
                              input logic [7:0] bad_val, input bit bubbles, input bit bad_tail);
        logic [63:0] d;
        logic [7:0]  c;
        int p;
        int r;
        send_word(8'h01, START_W);
        p = 0;
        while (p + 8 <= len) begin
            send_word(8'h00, pay_word(seed, p, bad_idx, bad_val));
            if (bubbles && (p % 16 == 0)) bubble();
            p += 8;
        end
        r = len - p;
        d = pay_word(seed, p, bad_idx, bad_val);
        c = 8'hFF;
        for (int k = 0; k < 8; k++) begin
            if (k < r) c[k] = 1'b0;
            else if (k > r) begin
                d[8*k +: 8] = bad_tail ? 8'h00 : 8'h07;
                if (bad_tail) c[k] = 1'b0;
            end
        end
        d[8*r +: 8] = 8'hFD;
        send_word(c, d);
    endtask

    task automatic snap();
        ok0  = ok_seen;
        err0 = err_seen;
    endtask

    initial begin
        rst_156_n = 1'b0;
        rx_rdy    = 1'b1;
        rx_ena    = 1'b0;
        rx_ctrl   = 8'hFF;
        rx_data   = IDLE_W;
        #10;
        check("reset_frame_ok", 32'(frame_ok), 0);
        check("reset_frame_err", 32'(frame_err), 0);
        check("reset_err_code", 32'(err_code), 0);
        check("reset_last_len", 32'(last_len), 0);
        check("reset_frame_cnt", frame_cnt, 0);
        check("reset_err_cnt", err_cnt, 0);
        @(negedge clk_156);
        rst_156_n = 1'b1;
        idle(4);

        // 64-byte frame, seed 0x00, FD in lane 0 of the following word
        snap();
        send_frame(8'h00, 64, -1, 8'h00, 1'b0, 1'b0);
        idle(3);
        check("t1_ok_pulses", 32'(ok_seen - ok0), 1);
        check("t1_err_pulses", 32'(err_seen - err0), 0);
        check("t1_last_len", 32'(last_len), 64);
        check("t1_frame_cnt", frame_cnt, 1);
        check("t1_err_cnt", err_cnt, 0);

        // 100-byte frame, seed 0xF0 wrapping through 0xFF, FD in lane 4
        snap();
        send_frame(8'hF0, 100, -1, 8'h00, 1'b0, 1'b0);
        idle(3);
        check("t2_ok_pulses", 32'(ok_seen - ok0), 1);
        check("t2_last_len", 32'(last_len), 100);
        check("t2_frame_cnt", frame_cnt, 2);

        // Byte 37 corrupted
        snap();
        send_frame(8'h11, 80, 37, 8'hAA, 1'b0, 1'b0);
        idle(3);
        check("t3_err_pulses", 32'(err_seen - err0), 1);
        check("t3_ok_pulses", 32'(ok_seen - ok0), 0);
        check("t3_err_code", 32'(err_code), 4);
        check("t3_last_len", 32'(last_len), 80);
        check("t3_err_cnt", err_cnt, 1);
        check("t3_frame_cnt", frame_cnt, 2);

        // Bad SFD, then a good frame
        snap();
        send_word(8'h01, 64'hD4555555555555FB);
        idle(3);
        check("t4_err_pulses", 32'(err_seen - err0), 1);
        check("t4_err_code", 32'(err_code), 1);
        check("t4_err_cnt", err_cnt, 2);
        snap();
        send_frame(8'h5A, 64, -1, 8'h00, 1'b0, 1'b0);
        idle(3);
        check("t4_good_ok", 32'(ok_seen - ok0), 1);
        check("t4_good_frame_cnt", frame_cnt, 3);
        check("t4_err_code_held", 32'(err_code), 1);

        // 2000-byte frame: one LONG error, nothing at the terminate
        snap();
        send_frame(8'h00, 2000, -1, 8'h00, 1'b0, 1'b0);
        idle(3);
        check("t5_long_err_pulses", 32'(err_seen - err0), 1);
        check("t5_long_ok_pulses", 32'(ok_seen - ok0), 0);
        check("t5_long_err_code", 32'(err_code), 6);
        check("t5_long_err_cnt", err_cnt, 3);
        check("t5_long_last_len", 32'(last_len), 64);

        // 40-byte frame: SHORT
        snap();
        send_frame(8'h03, 40, -1, 8'h00, 1'b0, 1'b0);
        idle(3);
        check("t5_short_err_pulses", 32'(err_seen - err0), 1);
        check("t5_short_err_code", 32'(err_code), 5);
        check("t5_short_last_len", 32'(last_len), 40);
        check("t5_short_err_cnt", err_cnt, 4);

        // Lane-4 start: ALIGN, then the next frame is swallowed by DROP
        snap();
        send_word(8'h1F, 64'h555555FB07070707);
        send_frame(8'h07, 64, -1, 8'h00, 1'b0, 1'b0);
        idle(3);
        check("t6_align_err_pulses", 32'(err_seen - err0), 1);
        check("t6_align_ok_pulses", 32'(ok_seen - ok0), 0);
        check("t6_align_err_code", 32'(err_code), 2);
        check("t6_align_err_cnt", err_cnt, 5);
        snap();
        send_frame(8'h07, 64, -1, 8'h00, 1'b0, 1'b0);
        idle(3);
        check("t6_after_drop_ok", 32'(ok_seen - ok0), 1);
        check("t6_after_drop_frame_cnt", frame_cnt, 4);

        // rx_rdy drop mid-frame: partial frame discarded silently
        snap();
        send_word(8'h01, START_W);
        for (int i = 0; i < 3; i++) send_word(8'h00, pay_word(8'h20, 8 * i, -1, 8'h00));
        @(negedge clk_156);
        rx_rdy = 1'b0;
        rx_ctrl = 8'h00;
        rx_data = pay_word(8'h20, 24, -1, 8'h00);
        @(negedge clk_156);
        rx_data = pay_word(8'h20, 32, -1, 8'h00);
        @(negedge clk_156);
        rx_rdy = 1'b1;
        for (int i = 5; i < 8; i++) send_word(8'h00, pay_word(8'h20, 8 * i, -1, 8'h00));
        send_word(8'hFF, 64'h07070707070707FD);
        idle(3);
        check("t7_rdy_ok_pulses", 32'(ok_seen - ok0), 0);
        check("t7_rdy_err_pulses", 32'(err_seen - err0), 0);
        snap();
        send_frame(8'h21, 64, -1, 8'h00, 1'b0, 1'b0);
        idle(3);
        check("t7_next_ok", 32'(ok_seen - ok0), 1);
        check("t7_frame_cnt", frame_cnt, 5);

        // rx_ena=0 bubbles carrying terminate-like garbage inside a frame
        snap();
        send_frame(8'h80, 72, -1, 8'h00, 1'b1, 1'b0);
        idle(3);
        check("t8_bubble_ok", 32'(ok_seen - ok0), 1);
        check("t8_bubble_err", 32'(err_seen - err0), 0);
        check("t8_last_len", 32'(last_len), 72);
        check("t8_frame_cnt", frame_cnt, 6);

        // Terminate followed by non-idle lanes: CTRL error, length still recorded
        snap();
        send_frame(8'h00, 68, -1, 8'h00, 1'b0, 1'b1);
        idle(3);
        check("t9_tail_err_pulses", 32'(err_seen - err0), 1);
        check("t9_tail_err_code", 32'(err_code), 3);
        check("t9_tail_last_len", 32'(last_len), 68);
        check("t9_tail_err_cnt", err_cnt, 6);

        // Start char mid-frame: CTRL error, and that word is not a new start
        snap();
        send_word(8'h01, START_W);
        send_word(8'h00, pay_word(8'h00, 0, -1, 8'h00));
        send_word(8'h00, pay_word(8'h00, 8, -1, 8'h00));
        send_word(8'h01, START_W);
        for (int i = 0; i < 8; i++) send_word(8'h00, pay_word(8'h00, 8 * i, -1, 8'h00));
        send_word(8'hFF, 64'h07070707070707FD);
        idle(3);
        check("t9_mid_err_pulses", 32'(err_seen - err0), 1);
        check("t9_mid_ok_pulses", 32'(ok_seen - ok0), 0);
        check("t9_mid_err_code", 32'(err_code), 3);
        check("t9_mid_err_cnt", err_cnt, 7);
        check("t9_mid_last_len", 32'(last_len), 68);

        // Asynchronous reset mid-frame
        send_word(8'h01, START_W);
        send_word(8'h00, pay_word(8'h00, 0, -1, 8'h00));
        @(negedge clk_156);
        rst_156_n = 1'b0;
        rx_ena = 1'b0;
        #1;
        check("t10_rst_frame_cnt", frame_cnt, 0);
        check("t10_rst_err_cnt", err_cnt, 0);
        check("t10_rst_last_len", 32'(last_len), 0);
        check("t10_rst_err_code", 32'(err_code), 0);
        @(negedge clk_156);
        rst_156_n = 1'b1;
        idle(4);
        snap();
        send_frame(8'h44, 64, -1, 8'h00, 1'b0, 1'b0);
        idle(3);
        check("t10_after_rst_ok", 32'(ok_seen - ok0), 1);
        check("t10_after_rst_frame_cnt", frame_cnt, 1);
        check("t10_after_rst_err_cnt", err_cnt, 0);

        check("ok_and_err_same_cycle", 32'(both_seen), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
